// File: rtl/sprite_pkg.sv
// Shared constants and types for the sprite motion block: HID keycodes,
// sprite-0 motion states and default screen geometry.
package sprite_pkg;

  localparam logic [7:0] KEY_W     = 8'h1A;
  localparam logic [7:0] KEY_S     = 8'h16;
  localparam logic [7:0] KEY_A     = 8'h04;
  localparam logic [7:0] KEY_D     = 8'h07;
  localparam logic [7:0] KEY_SPACE = 8'h2C;

  localparam int X_MAX    = 639;
  localparam int Y_MAX    = 479;
  localparam int X_CENTER = 320;
  localparam int Y_CENTER = 240;

  typedef enum logic [1:0] {IDLE, MOVE, PAUSED} motion_state_t;
  typedef enum logic [1:0] {DIR_UP, DIR_DOWN, DIR_LEFT, DIR_RIGHT} dir_t;

  function automatic logic key_known(input logic [7:0] k);
    return (k == KEY_W) || (k == KEY_S) || (k == KEY_A) || (k == KEY_D) || (k == KEY_SPACE);
  endfunction

endpackage

// File: rtl/sprite_axis.sv
// One axis of one sprite: velocity and position registers with edge bounce
// and clamping. Updates only when en is high (one frame tick).
module sprite_axis #(
  parameter int MAX     = 639,
  parameter int SIZE    = 4,
  parameter int RST_POS = 320,
  parameter int RST_VEL = 0
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              en,
  input  logic              cmd_vld,
  input  logic signed [3:0] cmd_vel,
  output logic [9:0]        pos
);
  localparam logic signed [11:0] LO = 12'(SIZE);
  localparam logic signed [11:0] HI = 12'(MAX - SIZE);

  logic signed [3:0]  vel, vel_b, vel_n;
  logic signed [11:0] sum;
  logic [9:0]         pos_n;
  logic               bounced;

  always_comb begin
    vel_b   = vel;
    bounced = 1'b0;
    if ((({2'b00, pos} + 12'(SIZE)) >= 12'(MAX)) && (vel > 4'sd0)) begin
      vel_b   = -vel;
      bounced = 1'b1;
    end else if ((pos <= 10'(SIZE)) && (vel < 4'sd0)) begin
      vel_b   = -vel;
      bounced = 1'b1;
    end
    // A key pushing back into the wall just hit is dropped for this tick.
    if (cmd_vld && !(bounced && (cmd_vel != 4'sd0) && (cmd_vel[3] == vel[3])))
      vel_n = cmd_vel;
    else
      vel_n = vel_b;
    sum = $signed({2'b00, pos}) + 12'(vel_n);
    if (sum < LO)      pos_n = LO[9:0];
    else if (sum > HI) pos_n = HI[9:0];
    else               pos_n = sum[9:0];
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      pos <= 10'(RST_POS);
      vel <= 4'(RST_VEL);
    end else if (en) begin
      pos <= pos_n;
      vel <= vel_n;
    end
  end

endmodule

// File: rtl/sprite_motion_ctrl.sv
// Frame-rate motion controller for NUM_SPRITES sprites: keyboard steering of
// sprite 0 with speed ramp and pause, auto-bounce of the rest, pixel hit test.
module sprite_motion_ctrl #(
  parameter  int NUM_SPRITES = 2,
  parameter  int KEY_SLOTS   = 2,
  parameter  int X_MAX       = sprite_pkg::X_MAX,
  parameter  int Y_MAX       = sprite_pkg::Y_MAX,
  parameter  int SIZE        = 4,
  parameter  int MAX_STEP    = 4,
  parameter  int RAMP_FRAMES = 8,
  localparam int IDX_W       = (NUM_SPRITES > 1) ? $clog2(NUM_SPRITES) : 1
) (
  input  logic                     Clk,
  input  logic                     Reset_n,
  input  logic                     frame_vs,
  input  logic [8*KEY_SLOTS-1:0]   keycode,
  input  logic [9:0]               DrawX,
  input  logic [9:0]               DrawY,
  output logic [10*NUM_SPRITES-1:0] pos_x,
  output logic [10*NUM_SPRITES-1:0] pos_y,
  output logic                     hit,
  output logic [IDX_W-1:0]         hit_idx,
  output logic                     paused,
  output logic [2:0]               step_cur
);
  import sprite_pkg::*;

  localparam int RAMP_W = $clog2(RAMP_FRAMES + 1);

  // [1:0] synchronise the vsync, [2] holds the previous synchronised level
  logic [2:0] vs_sync;
  logic       tick;

  always_ff @(posedge Clk or negedge Reset_n) begin
    if (!Reset_n) vs_sync <= '1;
    else          vs_sync <= {vs_sync[1:0], frame_vs};
  end
  assign tick = vs_sync[1] & ~vs_sync[2];

  logic [7:0] key_sel;
  logic       dir_vld, space_now;
  dir_t       dir;

  always_comb begin
    key_sel = '0;
    for (int s = KEY_SLOTS - 1; s >= 0; s--)
      if (key_known(keycode[8*s +: 8])) key_sel = keycode[8*s +: 8];
    dir_vld = 1'b1;
    dir     = DIR_UP;
    case (key_sel)
      KEY_W:   dir = DIR_UP;
      KEY_S:   dir = DIR_DOWN;
      KEY_A:   dir = DIR_LEFT;
      KEY_D:   dir = DIR_RIGHT;
      default: dir_vld = 1'b0;
    endcase
    space_now = (key_sel == KEY_SPACE);
  end

  motion_state_t     state, state_d, resume, resume_d;
  dir_t              dir_last, dir_last_d;
  logic [2:0]        step_d, step_base;
  logic [RAMP_W-1:0] ramp, ramp_d, ramp_base;
  logic              space_prev, space_prev_d, toggle, move_en, changed;

  // Pause toggles freeze motion on their own tick as well
  assign toggle  = space_now & ~space_prev;
  assign move_en = tick & ~toggle & (state != PAUSED);
  assign paused  = (state == PAUSED);

  always_ff @(posedge Clk or negedge Reset_n) begin
    if (!Reset_n) begin
      state      <= IDLE;
      resume     <= IDLE;
      dir_last   <= DIR_UP;
      step_cur   <= 3'd1;
      ramp       <= '0;
      space_prev <= 1'b0;
    end else begin
      state      <= state_d;
      resume     <= resume_d;
      dir_last   <= dir_last_d;
      step_cur   <= step_d;
      ramp       <= ramp_d;
      space_prev <= space_prev_d;
    end
  end

  always_comb begin
    changed      = (state == MOVE) && (dir != dir_last);
    step_base    = changed ? 3'd1 : step_cur;
    ramp_base    = ((state == MOVE) && !changed) ? ramp : '0;
    state_d      = state;
    resume_d     = resume;
    dir_last_d   = dir_last;
    step_d       = step_cur;
    ramp_d       = ramp;
    space_prev_d = space_prev;
    if (tick) begin
      space_prev_d = space_now;
      if (toggle) begin
        if (state == PAUSED) state_d = resume;
        else begin
          resume_d = state;
          state_d  = PAUSED;
        end
      end else if (state != PAUSED) begin
        if (dir_vld) begin
          state_d    = MOVE;
          dir_last_d = dir;
          if (ramp_base == RAMP_W'(RAMP_FRAMES - 1)) begin
            ramp_d = '0;
            step_d = (step_base >= 3'(MAX_STEP)) ? 3'(MAX_STEP) : step_base + 3'd1;
          end else begin
            ramp_d = ramp_base + RAMP_W'(1);
            step_d = step_base;
          end
        end else begin
          ramp_d = '0;
        end
      end
    end
  end

  // The step applied this tick is the pre-ramp one; an increment shows next tick
  logic signed [3:0] mag, vx_cmd, vy_cmd;

  always_comb begin
    mag    = $signed({1'b0, step_base});
    vx_cmd = 4'sd0;
    vy_cmd = 4'sd0;
    case (dir)
      DIR_RIGHT: vx_cmd = mag;
      DIR_LEFT:  vx_cmd = -mag;
      DIR_DOWN:  vy_cmd = mag;
      default:   vy_cmd = -mag;
    endcase
  end

  for (genvar i = 0; i < NUM_SPRITES; i++) begin : g_spr
    localparam bit LEAD = (i == 0);
    localparam int RV   = LEAD ? 0 : 1;
    sprite_axis #(.MAX(X_MAX), .SIZE(SIZE), .RST_POS(X_CENTER + 40*i), .RST_VEL(RV)) u_x (
      .clk(Clk), .rst_n(Reset_n), .en(move_en), .cmd_vld(LEAD && dir_vld),
      .cmd_vel(vx_cmd), .pos(pos_x[10*i +: 10]));
    sprite_axis #(.MAX(Y_MAX), .SIZE(SIZE), .RST_POS(Y_CENTER), .RST_VEL(RV)) u_y (
      .clk(Clk), .rst_n(Reset_n), .en(move_en), .cmd_vld(LEAD && dir_vld),
      .cmd_vel(vy_cmd), .pos(pos_y[10*i +: 10]));
  end

  function automatic logic near(input logic [9:0] a, input logic [9:0] b);
    logic [9:0] d;
    d = (a >= b) ? a - b : b - a;
    return d <= 10'(SIZE);
  endfunction

  logic             hit_d;
  logic [IDX_W-1:0] idx_d;

  always_comb begin
    hit_d = 1'b0;
    idx_d = '0;
    for (int i = NUM_SPRITES - 1; i >= 0; i--)
      if (near(DrawX, pos_x[10*i +: 10]) && near(DrawY, pos_y[10*i +: 10])) begin
        hit_d = 1'b1;
        idx_d = IDX_W'(i);
      end
  end

  always_ff @(posedge Clk or negedge Reset_n) begin
    if (!Reset_n) begin
      hit     <= 1'b0;
      hit_idx <= '0;
    end else begin
      hit     <= hit_d;
      hit_idx <= idx_d;
    end
  end

endmodule

// File: tb/tb_sprite_motion_ctrl.sv
// Directed bench for sprite_motion_ctrl: reset, drift, pause, ramp, key
// priority, wall bounce/clamp, hit test and mid-frame reset.
module tb_sprite_motion_ctrl;
  logic        Clk, Reset_n, frame_vs;
  logic [15:0] keycode;
  logic [9:0]  DrawX, DrawY;
  logic [19:0] pos_x, pos_y;
  logic        hit;
  logic [0:0]  hit_idx;
  logic        paused;
  logic [2:0]  step_cur;
  int          n_chk, n_bad;

  sprite_motion_ctrl dut (
    .Clk(Clk), .Reset_n(Reset_n), .frame_vs(frame_vs), .keycode(keycode),
    .DrawX(DrawX), .DrawY(DrawY), .pos_x(pos_x), .pos_y(pos_y),
    .hit(hit), .hit_idx(hit_idx), .paused(paused), .step_cur(step_cur));

  initial Clk = 1'b0;
  always #10 Clk = ~Clk;

  task automatic chk(input string tag, input int got, input int exp);
    n_chk++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0d want %0d", tag, got, exp);
    end
  endtask

  task automatic chk_pos(input string tag, input int x0, input int y0, input int x1, input int y1);
    chk({tag, ".x0"}, int'(pos_x[9:0]),   x0);
    chk({tag, ".y0"}, int'(pos_y[9:0]),   y0);
    chk({tag, ".x1"}, int'(pos_x[19:10]), x1);
    chk({tag, ".y1"}, int'(pos_y[19:10]), y1);
  endtask

  // One vsync pulse per frame; motion settles a few cycles after its rising edge
  task automatic tick_n(input int n);
    for (int k = 0; k < n; k++) begin
      @(negedge Clk) frame_vs = 1'b0;
      repeat (3) @(negedge Clk);
      frame_vs = 1'b1;
      repeat (5) @(negedge Clk);
    end
  endtask

  task automatic pix(input string tag, input int x, input int y, input int eh, input int ei);
    @(negedge Clk);
    DrawX = 10'(x);
    DrawY = 10'(y);
    @(negedge Clk);
    chk({tag, ".hit"}, int'(hit), eh);
    if (eh != 0) chk({tag, ".idx"}, int'(hit_idx), ei);
  endtask

  initial begin
    n_chk = 0; n_bad = 0;
    Reset_n = 1'b0; frame_vs = 1'b1; keycode = '0; DrawX = '0; DrawY = '0;
    repeat (3) @(negedge Clk);
    chk_pos("rst", 320, 240, 360, 240);
    chk("rst.step", int'(step_cur), 1);
    chk("rst.paused", int'(paused), 0);
    chk("rst.hit", int'(hit), 0);
    chk("rst.idx", int'(hit_idx), 0);
    Reset_n = 1'b1;
    repeat (2) @(negedge Clk);

    tick_n(3);
    chk_pos("idle3", 320, 240, 363, 243);

    // hit is registered: no change before the next clock edge
    @(negedge Clk);
    DrawX = 10'd320; DrawY = 10'd240;
    #1 chk("hit.lat", int'(hit), 0);
    @(negedge Clk);
    chk("hit.c0", int'(hit), 1);
    chk("hit.c0idx", int'(hit_idx), 0);
    pix("corner0", 324, 236, 1, 0);
    pix("edge1", 367, 247, 1, 1);
    pix("out1", 368, 243, 0, 0);
    pix("origin", 0, 0, 0, 0);

    // Space in slot 1: toggles once, holding does nothing more
    keycode = 16'h2C00;
    tick_n(1);
    chk("pause.on", int'(paused), 1);
    chk_pos("pause.t1", 320, 240, 363, 243);
    tick_n(4);
    chk("pause.hold", int'(paused), 1);
    chk("pause.x1", int'(pos_x[19:10]), 363);
    keycode = '0;
    tick_n(1);
    chk("pause.rel", int'(paused), 1);
    chk("pause.rel.x1", int'(pos_x[19:10]), 363);
    keycode = 16'h2C00;
    tick_n(1);
    chk("pause.off", int'(paused), 0);
    chk("pause.off.x1", int'(pos_x[19:10]), 363);
    keycode = '0;
    tick_n(1);
    chk_pos("resume", 320, 240, 364, 244);

    // Hold D: step ramps to 2 on the 8th tick
    keycode = 16'h0007;
    tick_n(7);
    chk("ramp7.x0", int'(pos_x[9:0]), 327);
    chk("ramp7.step", int'(step_cur), 1);
    tick_n(1);
    chk("ramp8.x0", int'(pos_x[9:0]), 328);
    chk("ramp8.step", int'(step_cur), 2);
    tick_n(1);
    chk_pos("ramp9", 330, 240, 373, 253);

    // Slot 0 (A) beats slot 1 (W); direction change drops step to 1
    keycode = 16'h1A04;
    tick_n(1);
    chk("prio.x0", int'(pos_x[9:0]), 329);
    chk("prio.y0", int'(pos_y[9:0]), 240);
    chk("prio.step", int'(step_cur), 1);
    tick_n(1);
    chk("prio2.x0", int'(pos_x[9:0]), 328);
    keycode = '0;
    tick_n(2);
    chk_pos("drift", 326, 240, 377, 257);

    // Sprite 1 reaches the bottom edge and bounces
    tick_n(217);
    chk_pos("pre_bot", 109, 240, 594, 474);
    tick_n(1);
    chk("bot.y1a", int'(pos_y[19:10]), 475);
    tick_n(1);
    chk("bot.y1b", int'(pos_y[19:10]), 474);
    tick_n(1);
    chk_pos("bot", 106, 240, 597, 473);

    // Hold A into the left wall; sprite 1 meets the right wall meanwhile
    keycode = 16'h0004;
    tick_n(24);
    chk("left24.x0", int'(pos_x[9:0]), 58);
    chk("left24.step", int'(step_cur), 4);
    tick_n(14);
    chk("clamp.x0", int'(pos_x[9:0]), 4);
    chk("rwall.x1", int'(pos_x[19:10]), 635);
    tick_n(1);
    chk("bounce.x0", int'(pos_x[9:0]), 8);
    chk("rbounce.x1", int'(pos_x[19:10]), 634);
    tick_n(1);
    chk_pos("walls", 4, 240, 633, 433);
    chk("walls.step", int'(step_cur), 4);

    // Mid-frame reset
    pix("spr1", 633, 433, 1, 1);
    keycode = '0;
    @(negedge Clk);
    Reset_n = 1'b0;
    #1;
    chk("mrst.hit", int'(hit), 0);
    chk("mrst.step", int'(step_cur), 1);
    chk("mrst.paused", int'(paused), 0);
    chk_pos("mrst", 320, 240, 360, 240);
    @(negedge Clk);
    Reset_n = 1'b1;
    tick_n(1);
    chk_pos("post_rst", 320, 240, 361, 241);

    $display("test done: total=%0d bad=%0d", n_chk, n_bad);
    $finish;
  end

endmodule
